// File: rtl/sprite_rom_arbiter_if.sv
// Requester-side bus of the sprite ROM arbiter: level requests with flattened
// addresses in, one-hot grant/response pulses and shared read data out.
interface sprite_rom_arbiter_if #(
  parameter int NREQ = 3,
  parameter int AW   = 12,
  parameter int DW   = 12
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;

  // Requester side drives requests and addresses
  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  // Arbiter side answers with grants and read data
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: shares the single sprite/tile ROM read port between NREQ
// requesters. Requester 0 (pixel fetch) has absolute priority while bright is
// high; otherwise grants rotate round-robin. One access in flight at a time:
// IDLE -> ISSUE -> WAIT (RD_LAT cycles) -> RESP -> IDLE.
// Optional feature macro ARB_WAIT_STATS_EN: per-requester saturating wait
// counters feeding the max_wait statistic; without it max_wait is 0.
module sprite_rom_arbiter #(
  parameter int NREQ   = 3,
  parameter int AW     = 12,
  parameter int DW     = 12,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bright,
  sprite_rom_arbiter_if.slave  bus,
  output logic                 mem_en,
  output logic [AW-1:0]        mem_addr,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy,
  output logic [7:0]           max_wait
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_r;
  logic [PW-1:0]     rr_r;
  logic [PW-1:0]     winner_r;
  logic [2:0]        cnt_r;
  logic [NREQ-1:0]   gnt_r;
  logic [NREQ-1:0]   rvalid_r;
  logic [DW-1:0]     rdata_r;
  logic [AW-1:0]     memAddr_r;
  logic              memEn_r;
  logic              busy_r;

  logic              prio_s;
  logic [PW-1:0]     pick_s;
  logic [PW-1:0]     nextRr_s;
  logic [AW-1:0]     addrSel_s;
  int                scanIdx_s;

  function automatic logic [NREQ-1:0] oneHot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] vec;
    vec      = {NREQ{1'b0}};
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Winner selection: bright-region priority for requester 0, else the first
  // set request scanning upward from the round-robin pointer with wrap-around
  always_comb begin
    prio_s    = bright & bus.req[0];
    pick_s    = rr_r;
    scanIdx_s = 0;
    // Scan from the far end so the candidate closest to rr is written last
    for (int k = NREQ - 1; k >= 0; k--) begin
      scanIdx_s = (int'(rr_r) + k >= NREQ) ? int'(rr_r) + k - NREQ : int'(rr_r) + k;
      pick_s    = bus.req[PW'(scanIdx_s)] ? PW'(scanIdx_s) : pick_s;
    end
    if (prio_s) begin
      pick_s = {PW{1'b0}};
    end else begin
      pick_s = pick_s;
    end
    nextRr_s  = (pick_s == PW'(NREQ - 1)) ? {PW{1'b0}} : pick_s + PW'(1);
    addrSel_s = bus.addr[int'(pick_s) * AW +: AW];
  end

  // Access sequencer with registered grant, ROM strobe, response and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rr_r      <= {PW{1'b0}};
      winner_r  <= {PW{1'b0}};
      cnt_r     <= 3'd0;
      gnt_r     <= {NREQ{1'b0}};
      rvalid_r  <= {NREQ{1'b0}};
      rdata_r   <= {DW{1'b0}};
      memAddr_r <= {AW{1'b0}};
      memEn_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rvalid_r <= {NREQ{1'b0}};
          if (|bus.req) begin
            winner_r  <= pick_s;
            // Priority grants to the pixel path leave the rotation untouched
            rr_r      <= prio_s ? rr_r : nextRr_s;
            memAddr_r <= addrSel_s;
            gnt_r     <= oneHot(pick_s);
            memEn_r   <= 1'b1;
            busy_r    <= 1'b1;
            state_r   <= ISSUE;
          end else begin
            state_r   <= IDLE;
          end
        end
        ISSUE: begin
          gnt_r   <= {NREQ{1'b0}};
          memEn_r <= 1'b0;
          cnt_r   <= 3'd0;
          state_r <= WAIT;
        end
        WAIT: begin
          // ROM data is valid in the last WAIT cycle; capture it on the way out
          if (cnt_r == 3'(RD_LAT - 1)) begin
            rdata_r  <= mem_rdata;
            rvalid_r <= oneHot(winner_r);
            state_r  <= RESP;
          end else begin
            cnt_r    <= cnt_r + 3'd1;
          end
        end
        RESP: begin
          rvalid_r <= {NREQ{1'b0}};
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          gnt_r    <= {NREQ{1'b0}};
          rvalid_r <= {NREQ{1'b0}};
          memEn_r  <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt    = gnt_r;
  assign bus.rvalid = rvalid_r;
  assign bus.rdata  = rdata_r;
  assign mem_en     = memEn_r;
  assign mem_addr   = memAddr_r;
  assign busy       = busy_r;

`ifdef ARB_WAIT_STATS_EN
  logic [7:0] waitCnt_r  [NREQ];
  logic [7:0] waitNext_s [NREQ];
  logic [7:0] maxNext_s;
  logic [7:0] maxWait_r;

  // Next wait-counter values and the running maximum including them
  always_comb begin
    maxNext_s = maxWait_r;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_r[i]) begin
        waitNext_s[i] = 8'd0;
      end else if (bus.req[i]) begin
        waitNext_s[i] = (waitCnt_r[i] == 8'hFF) ? waitCnt_r[i] : waitCnt_r[i] + 8'd1;
      end else begin
        waitNext_s[i] = waitCnt_r[i];
      end
      maxNext_s = (waitNext_s[i] > maxNext_s) ? waitNext_s[i] : maxNext_s;
    end
  end

  // Wait-statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        waitCnt_r[i] <= 8'd0;
      end
      maxWait_r <= 8'd0;
    end else begin
      waitCnt_r <= waitNext_s;
      maxWait_r <= maxNext_s;
    end
  end

  assign max_wait = maxWait_r;
`else
  assign max_wait = 8'd0;
`endif

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench for sprite_rom_arbiter: directed scenarios plus random
// traffic, all compared cycle by cycle against a transaction-timing model.
module tb_sprite_rom_arbiter;
  localparam int NREQ   = 3;
  localparam int AW     = 12;
  localparam int DW     = 12;
  localparam int RD_LAT = 2;

  logic          clk;
  logic          rst_n;
  logic          bright;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [7:0]    max_wait;

  sprite_rom_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  sprite_rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bright(bright), .bus(bus),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .busy(busy), .max_wait(max_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: data = ~addr, valid RD_LAT edges after the enable edge
  logic [DW-1:0] romPipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_en) romPipe[0] <= ~mem_addr;
    for (int k = 1; k < RD_LAT; k++) romPipe[k] <= romPipe[k-1];
  end
  assign mem_rdata = romPipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one access described by its sample cycle, winner, address
  int            cyc;
  bit            active;
  int            tStart;
  int            wIdx;
  logic [AW-1:0] wAddr;
  int            rr;
  logic [DW-1:0] mRdata;
  logic [AW-1:0] mMemAddr;
  int            mWait [NREQ];
  int            mMax;
  logic [NREQ-1:0] expGnt;
  int            glog[$];
  int            gcyc[$];

  function automatic logic [NREQ-1:0] gntAt(input int c);
    return (active && c == tStart + 1) ? NREQ'(1 << wIdx) : NREQ'(0);
  endfunction

  task automatic modelReset();
    active = 0; tStart = 0; wIdx = 0; rr = 0;
    mRdata = '0; mMemAddr = '0; mMax = 0;
    for (int i = 0; i < NREQ; i++) mWait[i] = 0;
  endtask

  // Apply the rules to the inputs of the current cycle (before its closing edge)
  task automatic modelSample();
    logic [NREQ-1:0] gCur;
    gCur = gntAt(cyc);
    for (int i = 0; i < NREQ; i++) begin
      if (gCur[i]) mWait[i] = 0;
      else if (bus.req[i]) mWait[i] = (mWait[i] < 255) ? mWait[i] + 1 : 255;
      if (mWait[i] > mMax) mMax = mWait[i];
    end
    if ((!active || cyc >= tStart + RD_LAT + 3) && bus.req != 0) begin
      if (bright && bus.req[0]) begin
        wIdx = 0;
      end else begin
        wIdx = -1;
        for (int k = 0; k < NREQ; k++)
          if (wIdx < 0 && bus.req[(rr + k) % NREQ]) wIdx = (rr + k) % NREQ;
        rr = (wIdx + 1) % NREQ;
      end
      wAddr  = bus.addr[wIdx*AW +: AW];
      tStart = cyc;
      active = 1;
    end
    if (active && cyc + 1 == tStart + 1) mMemAddr = wAddr;
    if (active && cyc + 1 == tStart + RD_LAT + 2) mRdata = DW'(~wAddr);
  endtask

  task automatic checkOutputs();
    logic [NREQ-1:0] ev;
    logic eb;
    int expMax;
    expGnt = gntAt(cyc);
    ev = (active && cyc == tStart + RD_LAT + 2) ? NREQ'(1 << wIdx) : NREQ'(0);
    eb = active && cyc >= tStart + 1 && cyc <= tStart + RD_LAT + 2;
`ifdef ARB_WAIT_STATS_EN
    expMax = mMax;
`else
    expMax = 0;
`endif
    checkVal("gnt", 32'(bus.gnt), 32'(expGnt));
    checkVal("rvalid", 32'(bus.rvalid), 32'(ev));
    checkVal("rdata", 32'(bus.rdata), 32'(mRdata));
    checkVal("mem_en", 32'(mem_en), 32'(expGnt != 0));
    checkVal("mem_addr", 32'(mem_addr), 32'(mMemAddr));
    checkVal("busy", 32'(busy), 32'(eb));
    checkVal("max_wait", 32'(max_wait), 32'(expMax));
    for (int i = 0; i < NREQ; i++)
      if (bus.gnt[i]) begin glog.push_back(i); gcyc.push_back(cyc); end
  endtask

  task automatic step(input bit holdReq);
    modelSample();
    @(posedge clk); #1; cyc++;
    checkOutputs();
    if (!holdReq) bus.req = bus.req & ~expGnt;
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    checkVal({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
    checkVal({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    checkVal({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    checkVal({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkVal({tag, "_busy"}, 32'(busy), 32'd0);
    checkVal({tag, "_max_wait"}, 32'(max_wait), 32'd0);
  endtask

  // Asynchronous assertion, checked right away; release away from the edge
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkZero(tag);
    modelReset();
    @(posedge clk); #1;
    checkVal({tag, "_rvalidHeld"}, 32'(bus.rvalid), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    int expMaxT6;
    rst_n = 1'b0; bright = 1'b0; bus.req = '0; bus.addr = '0;
    cyc = 0; expGnt = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkZero("reset");
    rst_n = 1'b1;

    // 1: single read by requester 1
    bus.req = 3'b010; bus.addr = {12'h000, 12'h0A5, 12'h000};
    glog.delete(); gcyc.delete();
    repeat (7) step(1'b0);
    checkVal("t1_gntWho", 32'(glog.size() > 0 ? glog[0] : -1), 32'd1);
    checkVal("t1_rdata", 32'(bus.rdata), 32'h0F5A);
    checkVal("t1_memAddr", 32'(mem_addr), 32'h00A5);

    // 2: round robin with all requests held
    doReset("t2rst");
    bus.req = 3'b111; bus.addr = {12'h333, 12'h222, 12'h111};
    glog.delete(); gcyc.delete();
    repeat (30) step(1'b1);
    checkVal("t2_count", 32'(glog.size()), 32'd6);
    for (int k = 0; k < 6 && k < glog.size(); k++) begin
      checkVal("t2_order", 32'(glog[k]), 32'(k % 3));
      if (k > 0) checkVal("t2_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd5);
    end

    // 3: bright priority, then back to round robin from rr = 0
    bright = 1'b1;
    repeat (6) step(1'b1);
    glog.delete(); gcyc.delete();
    repeat (20) step(1'b1);
    checkVal("t3_brightCount", 32'(glog.size()), 32'd4);
    foreach (glog[k]) checkVal("t3_brightWho", 32'(glog[k]), 32'd0);
    bright = 1'b0;
    glog.delete(); gcyc.delete();
    repeat (16) step(1'b1);
    for (int k = 0; k < 3; k++)
      checkVal("t3_after", 32'(k < glog.size() ? glog[k] : -1), 32'(k));

    // 4: pointer wrap-around
    doReset("t4rst");
    bus.req = 3'b010; bus.addr = {12'h444, 12'h555, 12'h666};
    repeat (6) step(1'b0);
    glog.delete(); gcyc.delete();
    bus.req = 3'b001;
    repeat (6) step(1'b0);
    bus.req = 3'b110;
    repeat (6) step(1'b0);
    checkVal("t4_first", 32'(glog.size() > 0 ? glog[0] : -1), 32'd0);
    checkVal("t4_second", 32'(glog.size() > 1 ? glog[1] : -1), 32'd1);
    bus.req = '0;
    repeat (6) step(1'b0);

    // 5: reset in WAIT after a grant to requester 2
    doReset("t5pre");
    bus.req = 3'b100; bus.addr = {12'h7E1, 12'h000, 12'h000};
    glog.delete(); gcyc.delete();
    step(1'b0);
    step(1'b0);
    checkVal("t5_granted2", 32'(glog.size() > 0 ? glog[0] : -1), 32'd2);
    doReset("t5mid");
    bus.req = 3'b111;
    glog.delete(); gcyc.delete();
    repeat (7) step(1'b1);
    checkVal("t5_rrZero", 32'(glog.size() > 0 ? glog[0] : -1), 32'd0);

    // 6: starvation of requester 2 under bright priority
    doReset("t6rst");
    bright = 1'b1; bus.req = 3'b101;
    repeat (300) step(1'b1);
`ifdef ARB_WAIT_STATS_EN
    expMaxT6 = 255;
`else
    expMaxT6 = 0;
`endif
    checkVal("t6_maxWait", 32'(max_wait), 32'(expMaxT6));

    // Random traffic
    doReset("rndrst");
    bright = 1'b0; bus.req = '0;
    for (int n = 0; n < 3000; n++) begin
      step(1'b1);
      for (int i = 0; i < NREQ; i++) begin
        if (expGnt[i]) begin
          if ($urandom_range(3) == 0) bus.addr[i*AW +: AW] = AW'($urandom);
          else bus.req[i] = 1'b0;
        end else if (bus.req[i]) begin
          if ($urandom_range(39) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(2) == 0) begin
          bus.req[i] = 1'b1;
          bus.addr[i*AW +: AW] = AW'($urandom);
        end
      end
      if ($urandom_range(19) == 0) bright = ~bright;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
